rq_rd_req_split: RTL

- Sits directly upstream of the PCIe Requester Request (RQ) AXIS port: s_axis_rq_* driving into the HCA/PCIe interface.
- Accepts DMA read commands of arbitrary byte length and splits each into PCIe memory-read TLPs, one 256-bit descriptor beat per TLP.
- Each TLP is no larger than the configured max read request size and never crosses a 4 KB boundary.
- Allocates a PCIe tag per TLP from a local pool, and publishes a per-tag record for the RC completion tracker.

---
 rtl/hca_dma_pkg.sv | 13 +
 rtl/rq_tag_pool.sv | 37 +++
 rtl/rq_rd_req_split.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hca_dma_pkg.sv
// hca_dma_pkg: RQ descriptor layout, request codes, MRRS decode and splitter FSM states
package hca_dma_pkg;
  localparam int DESC_ADDR_LSB  = 2;
  localparam int DESC_DWCNT_LSB = 64;
  localparam int DESC_DWCNT_W   = 11;
  localparam int DESC_REQ_LSB   = 75;
  localparam int DESC_TAG_LSB   = 96;
  localparam logic [3:0] REQ_MEM_RD = 4'b0000;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_TAG, ST_SEND} rq_state_e;
  function automatic logic [12:0] mrrs_bytes(input logic [2:0] code);
    return code >= 3'd5 ? 13'd4096 : 13'd128 << code;
  endfunction
endpackage

// File: rtl/rq_tag_pool.sv
// rq_tag_pool: free-tag bitmap handing out the lowest free tag and flagging bad frees
module rq_tag_pool #(
  parameter int NUM_TAGS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alloc,
  input  logic       free_valid,
  input  logic [7:0] free_tag,
  output logic [7:0] alloc_tag,
  output logic       empty,
  output logic       err_dbl_free
);
  localparam int TW = $clog2(NUM_TAGS);
  logic [NUM_TAGS-1:0] free_q, free_d;
  logic err_q, err_d, in_range;
  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) if (free_q[i]) alloc_tag = 8'(i);
    empty = ~|free_q;
    in_range = {1'b0, free_tag} < 9'(NUM_TAGS);
    err_d = free_valid && (!in_range || free_q[free_tag[TW-1:0]]);
    free_d = free_q;
    if (alloc && !empty) free_d[alloc_tag[TW-1:0]] = 1'b0;
    if (free_valid && !err_d) free_d[free_tag[TW-1:0]] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q <= '1;
      err_q <= 1'b0;
    end else begin
      free_q <= free_d;
      err_q <= err_d;
    end
  end
  assign err_dbl_free = err_q;
endmodule

// File: rtl/rq_rd_req_split.sv
// rq_rd_req_split: splits DMA read commands into MRRS/4KB-bounded PCIe MRd descriptors on the RQ port
module rq_rd_req_split
  import hca_dma_pkg::*;
#(
  parameter int C_DATA_WIDTH = 256,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32,
  parameter int LEN_WIDTH    = 16,
  parameter int ID_WIDTH     = 8,
  parameter int NUM_TAGS     = 32
) (
  input  logic                    pcie_clk,
  input  logic                    user_reset_n,
  input  logic [2:0]              cfg_max_read_req,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [63:0]             req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,
  input  logic [ID_WIDTH-1:0]     req_id,
  output logic                    s_axis_rq_tvalid,
  output logic                    s_axis_rq_tlast,
  output logic [C_DATA_WIDTH-1:0] s_axis_rq_tdata,
  output logic [59:0]             s_axis_rq_tuser,
  output logic [KEEP_WIDTH-1:0]   s_axis_rq_tkeep,
  input  logic                    s_axis_rq_tready,
  output logic                    tag_info_valid,
  output logic [7:0]              tag_info_tag,
  output logic [ID_WIDTH-1:0]     tag_info_id,
  output logic [LEN_WIDTH-1:0]    tag_info_offset,
  output logic [12:0]             tag_info_bytes,
  input  logic                    tag_free_valid,
  input  logic [7:0]              tag_free_tag,
  output logic                    err_dbl_free
);
  rq_state_e state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d, off_q, off_d, m1, ti_off_q, ti_off_d;
  logic [ID_WIDTH-1:0] id_q, id_d, ti_id_q, ti_id_d;
  logic [12:0] mrrs_q, mrrs_d, chunk_q, chunk_d, bnd, ti_bytes_q, ti_bytes_d;
  logic tvalid_q, tvalid_d, tlast_q, tlast_d, req_ready_q, req_ready_d, ti_valid_q, ti_valid_d;
  logic [C_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [59:0] tuser_q, tuser_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic [7:0] ti_tag_q, ti_tag_d, alloc_tag;
  logic [13:0] dw;
  logic [1:0] e;
  logic [3:0] fbe, lbe;
  logic [127:0] desc;
  logic alloc, empty, hs, one_dw;
  rq_tag_pool #(.NUM_TAGS(NUM_TAGS)) u_pool (
    .clk(pcie_clk), .rst_n(user_reset_n), .alloc(alloc), .free_valid(tag_free_valid),
    .free_tag(tag_free_tag), .alloc_tag(alloc_tag), .empty(empty), .err_dbl_free(err_dbl_free)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    off_d = off_q;
    id_d = id_q;
    mrrs_d = mrrs_q;
    chunk_d = chunk_q;
    tvalid_d = tvalid_q;
    tdata_d = tdata_q;
    tuser_d = tuser_q;
    tkeep_d = tkeep_q;
    ti_valid_d = 1'b0;
    ti_tag_d = ti_tag_q;
    ti_id_d = ti_id_q;
    ti_off_d = ti_off_q;
    ti_bytes_d = ti_bytes_q;
    alloc = 1'b0;
    bnd = 13'd4096 - 13'(addr_q[11:0]);
    m1 = rem_q < LEN_WIDTH'(mrrs_q) ? rem_q : LEN_WIDTH'(mrrs_q);
    dw = 14'(addr_q[1:0]) + 14'(chunk_q) + 14'd3;
    one_dw = dw[13:2] == 12'd1;
    e = addr_q[1:0] + chunk_q[1:0] - 2'd1;
    lbe = 4'hF >> (2'd3 - e);
    fbe = 4'hF << addr_q[1:0];
    desc = '0;
    desc[63:DESC_ADDR_LSB] = addr_q[63:DESC_ADDR_LSB];
    desc[DESC_DWCNT_LSB +: DESC_DWCNT_W] = dw[12:2];
    desc[DESC_REQ_LSB +: 4] = REQ_MEM_RD;
    desc[DESC_TAG_LSB +: 8] = alloc_tag;
    hs = state_q == ST_SEND && s_axis_rq_tready;
    if (state_q == ST_IDLE && req_valid && req_ready_q) begin
      addr_d = req_addr;
      rem_d = req_len;
      off_d = '0;
      id_d = req_id;
      mrrs_d = mrrs_bytes(cfg_max_read_req);
      state_d = req_len == '0 ? ST_IDLE : ST_CALC;
    end
    if (state_q == ST_CALC) begin
      chunk_d = m1 < LEN_WIDTH'(bnd) ? 13'(m1) : bnd;
      state_d = ST_TAG;
    end
    if (state_q == ST_TAG && !empty) begin
      alloc = 1'b1;
      tvalid_d = 1'b1;
      tdata_d = C_DATA_WIDTH'(desc);
      tuser_d = {52'b0, one_dw ? 4'h0 : lbe, one_dw ? fbe & lbe : fbe};
      tkeep_d = KEEP_WIDTH'(4'hF);
      state_d = ST_SEND;
    end
    if (hs) begin
      ti_valid_d = 1'b1;
      ti_tag_d = tdata_q[DESC_TAG_LSB +: 8];
      ti_id_d = id_q;
      ti_off_d = off_q;
      ti_bytes_d = chunk_q;
      addr_d = addr_q + 64'(chunk_q);
      off_d = off_q + LEN_WIDTH'(chunk_q);
      rem_d = rem_q - LEN_WIDTH'(chunk_q);
      tvalid_d = 1'b0;
      state_d = rem_d != '0 ? ST_CALC : ST_IDLE;
    end
    req_ready_d = state_d == ST_IDLE;
    tlast_d = tvalid_d;
  end
  always_ff @(posedge pcie_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q <= ST_IDLE;
      addr_q <= '0;
      rem_q <= '0;
      off_q <= '0;
      id_q <= '0;
      mrrs_q <= '0;
      chunk_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      tdata_q <= '0;
      tuser_q <= '0;
      tkeep_q <= '0;
      req_ready_q <= 1'b0;
      ti_valid_q <= 1'b0;
      ti_tag_q <= '0;
      ti_id_q <= '0;
      ti_off_q <= '0;
      ti_bytes_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      off_q <= off_d;
      id_q <= id_d;
      mrrs_q <= mrrs_d;
      chunk_q <= chunk_d;
      tvalid_q <= tvalid_d;
      tlast_q <= tlast_d;
      tdata_q <= tdata_d;
      tuser_q <= tuser_d;
      tkeep_q <= tkeep_d;
      req_ready_q <= req_ready_d;
      ti_valid_q <= ti_valid_d;
      ti_tag_q <= ti_tag_d;
      ti_id_q <= ti_id_d;
      ti_off_q <= ti_off_d;
      ti_bytes_q <= ti_bytes_d;
    end
  end
  assign req_ready = req_ready_q;
  assign s_axis_rq_tvalid = tvalid_q;
  assign s_axis_rq_tlast = tlast_q;
  assign s_axis_rq_tdata = tdata_q;
  assign s_axis_rq_tuser = tuser_q;
  assign s_axis_rq_tkeep = tkeep_q;
  assign tag_info_valid = ti_valid_q;
  assign tag_info_tag = ti_tag_q;
  assign tag_info_id = ti_id_q;
  assign tag_info_offset = ti_off_q;
  assign tag_info_bytes = ti_bytes_q;
endmodule
